// File: rtl/adc_readout_sm.sv
// adc_readout_sm: serializes one stored fill from the read FIFO into 32-bit beats and verifies its checksum
module adc_readout_sm #(
    parameter int BCNT_W = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         acq_enabled,
    input  logic         rd_start,
    input  logic [127:0] fifo_dat,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    output logic [31:0]  out_dat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         rd_done,
    output logic         chksum_err
);
    typedef enum logic [2:0] {IDLE, FILL_HDR, WFM_HDR, BURST, CHECKSUM, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] beat;
    logic [1:0] sel;
    logic [127:0] chk;
    logic [BCNT_W-1:0] burst_cnt;
    logic tail;
    logic start;
    logic load;
    logic pop;

    // next state, beat-load strobe and FIFO pop; tail blocks loads once the checksum word is popped
    always_comb begin
        start = (state == IDLE) && rd_start && !acq_enabled;
        load = (state inside {FILL_HDR, WFM_HDR, BURST, CHECKSUM}) && !tail && (!out_valid || out_ready) && !fifo_empty;
        pop = load && (beat == 2'd3);
        sel = ~beat;
        fifo_rd_en = pop;
        busy = state != IDLE;
        rd_done = state == DONE;
        state_nx = state;
        case (state)
            IDLE:     state_nx = start ? FILL_HDR : IDLE;
            FILL_HDR: state_nx = pop ? WFM_HDR : FILL_HDR;
            WFM_HDR:  state_nx = !pop ? WFM_HDR : (burst_cnt != '0) ? BURST : CHECKSUM;
            BURST:    state_nx = (pop && burst_cnt == BCNT_W'(1)) ? CHECKSUM : BURST;
            CHECKSUM: state_nx = (out_valid && out_ready && out_last) ? DONE : CHECKSUM;
            default:  state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // output register, beat index, burst counter and running checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            out_dat <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            beat <= '0;
            chk <= '0;
            burst_cnt <= '0;
            chksum_err <= 1'b0;
            tail <= 1'b0;
        end else begin
            if (start) begin
                chk <= '0;
                chksum_err <= 1'b0;
                beat <= '0;
                tail <= 1'b0;
            end
            if (load) begin
                out_dat <= fifo_dat[{sel, 5'd0} +: 32];
                out_valid <= 1'b1;
                out_last <= (state == CHECKSUM) && (beat == 2'd3);
                beat <= beat + 2'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last <= 1'b0;
            end
            if (load && state == WFM_HDR && beat == 2'd0) burst_cnt <= fifo_dat[BCNT_W-1:0];
            if (pop && state == BURST) burst_cnt <= burst_cnt - BCNT_W'(1);
            if (pop && (state == WFM_HDR || state == BURST)) chk <= chk ^ fifo_dat;
            if (pop && state == CHECKSUM) begin
                chksum_err <= fifo_dat != chk;
                tail <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adc_readout_sm.sv
// tb_adc_readout_sm: directed bench for adc_readout_sm with a FIFO stub and beat capture
module tb_adc_readout_sm;
    logic clk = 1'b0;
    logic reset, acq_enabled, rd_start, fifo_empty, fifo_rd_en;
    logic out_valid, out_ready, out_last, busy, rd_done, chksum_err;
    logic [127:0] fifo_dat;
    logic [31:0] out_dat;

    adc_readout_sm #(.BCNT_W(23)) dut (
        .clk(clk), .reset(reset), .acq_enabled(acq_enabled), .rd_start(rd_start),
        .fifo_dat(fifo_dat), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .rd_done(rd_done), .chksum_err(chksum_err)
    );

    always #5 clk = ~clk;

    logic [127:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic hold_empty = 1'b0;
    logic flush = 1'b0;
    int pops = 0;
    int cyc = 0;
    assign fifo_dat = mem[rd_ptr[4:0]];
    assign fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

    // FIFO read side, pop counter and cycle counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) pops <= pops + 1;
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    logic [31:0] cap[$];
    logic lastq[$];
    int last_cyc = -1;
    int done_cyc = -1;
    int done_pulses = 0;
    int unstable = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;

    // capture transfers mid-cycle and flag any change of a stalled beat
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            cap.push_back(out_dat);
            lastq.push_back(out_last);
            if (out_last) last_cyc = cyc;
        end
        if (rd_done) begin
            done_pulses++;
            done_cyc = cyc;
        end
        if (prev_stall && (out_valid !== 1'b1 || out_dat !== prev_dat)) unstable++;
        prev_stall = out_valid && !out_ready;
        prev_dat = out_dat;
    end

    int tests = 0;
    int fails = 0;
    logic [127:0] exp_w [0:7];
    int nexp = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [127:0] w);
        mem[wr_ptr[4:0]] = w;
        wr_ptr++;
        exp_w[nexp] = w;
        nexp++;
    endtask

    task automatic pulse_start();
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
    endtask

    task automatic run(input int budget, input bit tog, input int e_at, input int e_len, input int s_at);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (tog) out_ready = ~out_ready;
            hold_empty = (e_len > 0) && (i >= e_at) && (i < e_at + e_len);
            rd_start = (i == s_at);
            if (rd_done) begin
                ok = 1'b1;
                break;
            end
        end
        rd_start = 1'b0;
        hold_empty = 1'b0;
        out_ready = 1'b1;
        check("done_seen", 128'(ok), 128'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 128'(rd_done), 128'd0);
        check("idle_after", 128'(busy), 128'd0);
        check("done_timing", 128'(done_cyc), 128'(last_cyc + 1));
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_count"}, 128'(cap.size() - base), 128'(nexp * 4));
        for (int w = 0; w < nexp; w++)
            for (int b = 0; b < 4; b++)
                if (base + 4 * w + b < cap.size()) begin
                    check({tag, "_beat"}, 128'(cap[base + 4 * w + b]), 128'(32'(exp_w[w] >> (96 - 32 * b))));
                    check({tag, "_last"}, 128'(lastq[base + 4 * w + b]), 128'(w == nexp - 1 && b == 3));
                end
    endtask

    initial begin
        logic [127:0] f, wh, b1, b2, ck, w0;
        int base, p0, d0;
        reset = 1'b1; acq_enabled = 1'b0; rd_start = 1'b0; out_ready = 1'b1;
        f  = 128'hF111_0000_F222_0000_F333_0000_F444_0000;
        wh = 128'hA5A5_0001_5A5A_0002_C3C3_0003_0000_0002;
        b1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        b2 = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
        ck = wh ^ b1 ^ b2;
        w0 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DD80_0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(rd_done), 128'd0);
        check("rst_err", 128'(chksum_err), 128'd0);
        check("rst_rden", 128'(fifo_rd_en), 128'd0);
        check("rst_dat", 128'(out_dat), 128'd0);
        check("rst_last", 128'(out_last), 128'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        nexp = 0; push(f); push(wh); push(b1); push(b2); push(ck);
        base = cap.size(); p0 = pops; d0 = done_pulses;
        pulse_start();
        check("lat_t1_valid", 128'(out_valid), 128'd0);
        check("lat_t1_busy", 128'(busy), 128'd1);
        @(posedge clk); #1;
        check("lat_t2_valid", 128'(out_valid), 128'd1);
        check("lat_t2_dat", 128'(out_dat), 128'(f[127:96]));
        run(200, 1'b0, 0, 0, 10);
        check_stream("good", base);
        check("good_pops", 128'(pops - p0), 128'd5);
        check("good_done_pulses", 128'(done_pulses - d0), 128'd1);
        check("good_err", 128'(chksum_err), 128'd0);

        nexp = 0; push(f); push(wh); push(b1); push(b2); push(ck ^ 128'd1);
        base = cap.size();
        pulse_start();
        run(200, 1'b0, 0, 0, -1);
        check_stream("bad", base);
        check("bad_bit0", 128'(cap[base + 19]), 128'(ck[31:0] ^ 32'd1));
        check("bad_err", 128'(chksum_err), 128'd1);
        acq_enabled = 1'b1;
        pulse_start();
        check("acq_block_busy", 128'(busy), 128'd0);
        @(posedge clk); #1;
        check("acq_block_busy2", 128'(busy), 128'd0);
        check("bad_err_sticky", 128'(chksum_err), 128'd1);
        acq_enabled = 1'b0;

        nexp = 0; push(f); push(w0); push(w0);
        base = cap.size(); p0 = pops;
        pulse_start();
        run(200, 1'b0, 0, 0, -1);
        check_stream("zero", base);
        check("zero_pops", 128'(pops - p0), 128'd3);
        check("zero_err", 128'(chksum_err), 128'd0);

        nexp = 0; push(f); push(wh); push(b1); push(b2); push(ck);
        base = cap.size(); p0 = pops;
        pulse_start();
        run(400, 1'b1, 20, 5, -1);
        check_stream("stall", base);
        check("stall_pops", 128'(pops - p0), 128'd5);
        check("stall_stable", 128'(unstable), 128'd0);
        check("stall_err", 128'(chksum_err), 128'd0);

        nexp = 0; push(f); push(wh); push(b1); push(b2); push(ck);
        base = cap.size();
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (cap.size() - base >= 6) break;
            @(posedge clk); #1;
        end
        check("pre_reset_beats", 128'(cap.size() - base), 128'd6);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_valid", 128'(out_valid), 128'd0);
        check("mid_reset_busy", 128'(busy), 128'd0);
        reset = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        nexp = 0; push(f); push(wh); push(b1); push(b2); push(ck);
        base = cap.size(); p0 = pops;
        pulse_start();
        run(200, 1'b0, 0, 0, -1);
        check_stream("after_reset", base);
        check("after_reset_pops", 128'(pops - p0), 128'd5);
        check("after_reset_err", 128'(chksum_err), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
